// File: rtl/timer_intc.sv
// timer_intc: prescaled timer plus external edge interrupt controller with acked, sticky-overrun requests.
// Ports: clk, reset (sync, active-high); timer_e/period start, restart or stop the timer;
// ext_irq is an async line; intr_ack[0]/[1] clear intr1/intr2; missed[1:0] flag events lost
// while the request was pending; busy is high while the timer runs.
// Optional: define TIMER_AUTO_RELOAD_EN to make the timer periodic, reloading the period latched at timer_e.
module timer_intc #(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 4,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_e,
  input  logic [WIDTH-1:0] period,
  input  logic             ext_irq,
  input  logic [1:0]       intr_ack,
  output logic             intr1,
  output logic             intr2,
  output logic [1:0]       missed,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);
  state_t state;
  logic [WIDTH-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic s1, s2, h;
  logic [1:0] pend, ev;
  assign ev[0] = state == RUN && !timer_e && pre == '0 && cnt == WIDTH'(1);
  assign ev[1] = s2 & ~h;
  assign busy = state == RUN;
  assign intr1 = pend[0];
  assign intr2 = pend[1];
`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] per_q;
  always_ff @(posedge clk) begin
    if (reset) per_q <= '0;
    else if (timer_e) per_q <= period;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
    end else if (timer_e) begin
      state <= period != '0 ? RUN : IDLE;
      cnt <= period;
      pre <= PRE_TOP;
    end else if (state == RUN) begin
      if (pre != '0) pre <= pre - PRE_W'(1);
      else if (cnt != WIDTH'(1)) begin
        pre <= PRE_TOP;
        cnt <= cnt - WIDTH'(1);
      end else begin
`ifdef TIMER_AUTO_RELOAD_EN
        pre <= PRE_TOP;
        cnt <= per_q;
`else
        state <= IDLE;
`endif
      end
    end
  end
  // An event beats a same-cycle ack; missed only records events that were truly lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, h} <= '0;
      pend <= '0;
      missed <= '0;
    end else begin
      s1 <= ext_irq;
      s2 <= s1;
      h <= s2;
      for (int i = 0; i < 2; i++) begin
        if (ev[i]) begin
          pend[i] <= 1'b1;
          if (pend[i] && !intr_ack[i]) missed[i] <= 1'b1;
        end else if (intr_ack[i] && pend[i]) begin
          pend[i] <= 1'b0;
          missed[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_timer_intc.sv
// tb_timer_intc: randomized scoreboard bench for timer_intc against a deadline-based reference model.
module tb_timer_intc;
  localparam int P = 3;
  localparam int NCYC = 4400;
  logic clk, reset, timer_e, ext_irq, intr1, intr2, busy;
  logic [7:0] period;
  logic [1:0] intr_ack, missed;
  timer_intc #(.WIDTH(8), .PRESCALE(P), .PRE_W(16)) dut (
    .clk(clk), .reset(reset), .timer_e(timer_e), .period(period), .ext_irq(ext_irq),
    .intr_ack(intr_ack), .intr1(intr1), .intr2(intr2), .missed(missed), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  logic [4:0] exq[$];
  int cq[$];
  int vec = 0, bad = 0, k = 0, per = 0;
  longint deadline = 0;
  bit run = 0;
  logic [1:0] pm1 = 0, pm2 = 0;
  bit ext_h[0:NCYC+4];
  function automatic logic [1:0] pupd(input logic [1:0] pm, input logic e, input logic a);
    if (e) return {1'b1, pm[0] | (pm[1] & ~a)};
    if (a && pm[1]) return 2'b00;
    return pm;
  endfunction
  task automatic step(input logic r, input logic te, input logic [7:0] pv, input logic ex, input logic [1:0] ak);
    logic e1, e2;
    @(negedge clk);
    reset = r; timer_e = te; period = pv; ext_irq = ex; intr_ack = ak;
    ext_h[k+3] = ex;
    e1 = 0;
    e2 = 0;
    if (r) begin
      run = 0; pm1 = 0; pm2 = 0;
      ext_h[k+3] = 0; ext_h[k+2] = 0; ext_h[k+1] = 0;
    end else begin
      if (te) begin
        run = pv != 0;
        deadline = k + pv * P;
        per = pv;
      end else if (run && k == deadline) begin
        e1 = 1;
`ifdef TIMER_AUTO_RELOAD_EN
        deadline += per * P;
`else
        run = 0;
`endif
      end
      e2 = ext_h[k+1] & ~ext_h[k];
      pm1 = pupd(pm1, e1, ak[0]);
      pm2 = pupd(pm2, e2, ak[1]);
    end
    exq.push_back({run, pm1[1], pm2[1], pm2[0], pm1[0]});
    cq.push_back(k);
    k++;
  endtask
  always @(posedge clk) begin
    logic [4:0] e, a;
    int c;
    #1;
    if (exq.size() != 0) begin
      e = exq.pop_front();
      c = cq.pop_front();
      a = {busy, intr1, intr2, missed};
      vec++;
      if (a !== e) begin
        bad++;
        $display("FAIL outs cycle %0d: {busy,intr1,intr2,missed} got %b expected %b", c, a, e);
      end
    end
  end
  initial begin
    reset = 1; timer_e = 0; period = 0; ext_irq = 0; intr_ack = 0;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0); repeat (16) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b01); step(0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0); repeat (5) step(0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0); repeat (8) step(0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0); repeat (15) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); repeat (9) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b10); step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b01); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 2'b10); step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 2'b10); repeat (3) step(0, 0, 0, 0, 0);
    step(0, 1, 10, 0, 0); repeat (5) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); repeat (40) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic r, te, ex;
      logic [7:0] pv;
      logic [1:0] ak;
      r = $urandom_range(0, 299) == 0;
      te = $urandom_range(0, 24) == 0;
      pv = $urandom_range(0, 15) == 0 ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 6));
      ex = ext_irq ^ ($urandom_range(0, 3) == 0);
      ak = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
      step(r, te, pv, ex, ak);
    end
    @(posedge clk);
    #2;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/timer_intc.md
Name: timer_intc

Overview:
- Responder side of the control unit's `timer_e` / `intr1` / `intr2` interface.
- Accepts the one-cycle timer-start strobe issued by the timer opcode and counts out a programmed period through a prescaler.
- Raises `intr1` on expiry and `intr2` on a rising edge of an external interrupt line.
- Holds each request until the CPU acknowledges it. Sits beside the data path, with `period` taken from the register-bank read bus.

Parameters:
- WIDTH, 8, width of the period value and of the main down-counter
- PRESCALE, 4, clock cycles per counter tick; legal values 1..65535
- PRE_W, 16, prescaler register width; must hold PRESCALE-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- timer_e  input  1  start/restart strobe from control unit, sampled each rising edge
- period  input  WIDTH  tick count loaded when timer_e=1; 0 means stop
- ext_irq  input  1  asynchronous external interrupt line
- intr_ack  input  2  bit0 clears intr1 pending, bit1 clears intr2 pending
- intr1  output  1  timer interrupt request, level, held until acked
- intr2  output  1  external interrupt request, level, held until acked
- missed  output  2  sticky flags: an event arrived while the matching request was already pending
- busy  output  1  high while the timer is in RUN

Behaviour:
- Reset (sync, active-high, overrides everything) clears:
  - state to IDLE; cnt, pre, pend1, pend2, missed all to 0
  - both synchroniser flops and the edge-history flop to 0
  - all outputs therefore read 0 from the cycle after the reset edge.
- Reset mid-count aborts silently; no interrupt is issued.
- Timer FSM states: IDLE, RUN.
- timer_e=1 at any edge, in any state:
  - period!=0: cnt<=period, pre<=PRESCALE-1, state<=RUN. This is a restart if already running.
  - period==0: state<=IDLE; the count is cancelled and no interrupt is issued.
- RUN, timer_e=0, each edge:
  - pre!=0: pre<=pre-1.
  - pre==0 and cnt>1: pre<=PRESCALE-1, cnt<=cnt-1.
  - pre==0 and cnt==1: expiry event; state<=IDLE (one-shot).
- Latency: if timer_e is sampled at edge t with period N, expiry occurs at edge t+N*PRESCALE and intr1 is high from that edge.
- busy=1 exactly while state==RUN.
- External path:
  - ext_irq passes through a 2-flop synchroniser (s1, s2), then a history flop h.
  - Rising-edge event = s2 & ~h.
  - ext_irq rising before edge k gives pend2 set at edge k+2.
  - Level-high or falling ext_irq produces no event.
- Pending logic, per source i:
  - event: pend_i<=1; if pend_i was already 1, missed[i-1]<=1.
  - intr_ack[i-1]=1 without a same-cycle event: pend_i<=0 and missed[i-1]<=0.
  - Event and ack in the same cycle: set wins. pend_i stays 1 and missed is not set.
  - intr1=pend1, intr2=pend2, registered outputs with no combinational path from inputs.
- Ack of a source that is not pending has no effect.
- Both sources are independent; simultaneous events set both.
- Arithmetic: counters are unsigned and never wrap, because decrement only happens when the value is nonzero.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined:
  - on expiry the timer reloads cnt from the period value latched at the last timer_e, with pre<=PRESCALE-1, and stays in RUN.
  - interrupts recur every N*PRESCALE cycles until timer_e arrives with period==0, or reset.
  - A latched-period register of WIDTH bits is added.
- Undefined: one-shot behaviour as above; no latched-period register.

Test Plan:
- Reset held 2 cycles mid-RUN (PRESCALE=4, period=10) -> busy, intr1, intr2, missed all 0 after the reset edge; no intr1 ever follows.
- PRESCALE=1, timer_e with period=5 at edge 0 -> busy=1 at edges 1..4, intr1 rises at edge 5, busy=0. intr_ack=2'b01 at edge 8 -> intr1=0 from edge 8.
- PRESCALE=4, period=3 at edge 0, restart with period=2 at edge 6 -> intr1 rises at edge 14, not at edge 12.
- PRESCALE=1, period=4 at edge 0, timer_e with period=0 at edge 2 -> busy=0 from edge 2; intr1 stays 0 for 20 cycles.
- ext_irq pulses high before edges 10 and 20, no ack -> intr2 rises at edge 12, missed=2'b10 at edge 22. intr_ack=2'b10 at edge 25 -> intr2=0 and missed=0. Ack and a new edge event coinciding -> intr2 stays 1.
- TIMER_AUTO_RELOAD_EN defined, PRESCALE=2, period=3 at edge 0, ack issued 1 cycle after each rise -> intr1 rises at edges 6, 12, 18; missed[0] stays 0. Without the ack, missed[0]=1 at edge 12.
